// File: rtl/thunderbird_lights_gen.sv
// Thunderbird-style tail-light generator with LAMPS lamps per side.
// Turn requests light the lamps one by one from the inner lamp outwards.
// A hazard request, or left and right together, flashes both banks.
// A prescaler divides clk so that the pattern advances once every TICK_DIV clocks.
module thunderbird_lights_gen #(
  parameter int LAMPS    = 3,
  parameter int TICK_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left,
  input  logic             right,
  input  logic             hazard,
  output logic [LAMPS-1:0] l_lamps,
  output logic [LAMPS-1:0] r_lamps,
  output logic             busy
);

  // Reject illegal parameter values at elaboration time.
  if (LAMPS < 1) begin : g_bad_lamps
    $fatal(1, "thunderbird_lights_gen: LAMPS must be >= 1");
  end
  if (TICK_DIV < 1) begin : g_bad_div
    $fatal(1, "thunderbird_lights_gen: TICK_DIV must be >= 1");
  end

  localparam int SW = $clog2(LAMPS + 1);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LSEQ = 2'd1,
    RSEQ = 2'd2,
    HAZ  = 2'd3
  } state_t;

  state_t            state_q;
  logic [SW-1:0]     step_q;
  logic [CW-1:0]     tick_cnt_q;
  logic [LAMPS-1:0]  l_lamps_q;
  logic [LAMPS-1:0]  r_lamps_q;
  logic              busy_q;

  logic              tick_s;
  logic              haz_req_s;

  // Thermometer code: bits [n-1:0] set, the rest clear.
  function automatic logic [LAMPS-1:0] therm(input logic [SW-1:0] n);
    logic [LAMPS-1:0] v;
    v = {LAMPS{1'b0}};
    for (int i = 0; i < LAMPS; i++) begin
      v[i] = (i < int'(n));
    end
    return v;
  endfunction

  // Tick strobe and combined hazard request.
  always_comb begin
    tick_s    = (tick_cnt_q == CW'(TICK_DIV - 1));
    haz_req_s = hazard | (left & right);
  end

  // Prescaler, sequencer FSM and registered lamp outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      step_q     <= {SW{1'b0}};
      tick_cnt_q <= {CW{1'b0}};
      l_lamps_q  <= {LAMPS{1'b0}};
      r_lamps_q  <= {LAMPS{1'b0}};
      busy_q     <= 1'b0;
    end else begin
      if (tick_s) begin
        tick_cnt_q <= {CW{1'b0}};
      end else begin
        tick_cnt_q <= tick_cnt_q + CW'(1);
      end

      if (tick_s) begin
        case (state_q)
          IDLE: begin
            if (haz_req_s) begin
              state_q   <= HAZ;
              step_q    <= {SW{1'b0}};
              l_lamps_q <= {LAMPS{1'b1}};
              r_lamps_q <= {LAMPS{1'b1}};
              busy_q    <= 1'b1;
            end else if (left) begin
              state_q   <= LSEQ;
              step_q    <= SW'(1);
              l_lamps_q <= therm(SW'(1));
              r_lamps_q <= {LAMPS{1'b0}};
              busy_q    <= 1'b1;
            end else if (right) begin
              state_q   <= RSEQ;
              step_q    <= SW'(1);
              l_lamps_q <= {LAMPS{1'b0}};
              r_lamps_q <= therm(SW'(1));
              busy_q    <= 1'b1;
            end else begin
              state_q   <= IDLE;
              step_q    <= {SW{1'b0}};
              l_lamps_q <= {LAMPS{1'b0}};
              r_lamps_q <= {LAMPS{1'b0}};
              busy_q    <= 1'b0;
            end
          end
          LSEQ, RSEQ: begin
            if (haz_req_s) begin
              // Only a hazard request may cut a running sequence short.
              state_q   <= HAZ;
              step_q    <= {SW{1'b0}};
              l_lamps_q <= {LAMPS{1'b1}};
              r_lamps_q <= {LAMPS{1'b1}};
              busy_q    <= 1'b1;
            end else if (step_q < SW'(LAMPS)) begin
              step_q <= step_q + SW'(1);
              busy_q <= 1'b1;
              if (state_q == LSEQ) begin
                l_lamps_q <= therm(step_q + SW'(1));
                r_lamps_q <= {LAMPS{1'b0}};
              end else begin
                l_lamps_q <= {LAMPS{1'b0}};
                r_lamps_q <= therm(step_q + SW'(1));
              end
            end else begin
              // All lamps were lit: spend one step dark before re-arming.
              state_q   <= IDLE;
              step_q    <= {SW{1'b0}};
              l_lamps_q <= {LAMPS{1'b0}};
              r_lamps_q <= {LAMPS{1'b0}};
              busy_q    <= 1'b0;
            end
          end
          HAZ: begin
            // Dark half of the flash; IDLE re-enters HAZ if the request persists.
            state_q   <= IDLE;
            step_q    <= {SW{1'b0}};
            l_lamps_q <= {LAMPS{1'b0}};
            r_lamps_q <= {LAMPS{1'b0}};
            busy_q    <= 1'b0;
          end
          default: begin
            state_q   <= IDLE;
            step_q    <= {SW{1'b0}};
            l_lamps_q <= {LAMPS{1'b0}};
            r_lamps_q <= {LAMPS{1'b0}};
            busy_q    <= 1'b0;
          end
        endcase
      end else begin
        state_q   <= state_q;
        step_q    <= step_q;
        l_lamps_q <= l_lamps_q;
        r_lamps_q <= r_lamps_q;
        busy_q    <= busy_q;
      end
    end
  end

  assign l_lamps = l_lamps_q;
  assign r_lamps = r_lamps_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_thunderbird_lights_gen.sv
// Directed bench for thunderbird_lights_gen across several LAMPS/TICK_DIV sets.
module tb_thunderbird_lights_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: LAMPS=3 TICK_DIV=1
  logic a_rst, a_l, a_r, a_h, a_busy;
  logic [2:0] a_ll, a_rl;
  // Instance B: LAMPS=3 TICK_DIV=4
  logic b_rst, b_l, b_r, b_h, b_busy;
  logic [2:0] b_ll, b_rl;
  // Instance C: LAMPS=4 TICK_DIV=1
  logic c_rst, c_l, c_r, c_h, c_busy;
  logic [3:0] c_ll, c_rl;
  // Instance D: LAMPS=3 TICK_DIV=2
  logic d_rst, d_l, d_r, d_h, d_busy;
  logic [2:0] d_ll, d_rl;
  // Instance E: LAMPS=5 TICK_DIV=3
  logic e_rst, e_l, e_r, e_h, e_busy;
  logic [4:0] e_ll, e_rl;

  thunderbird_lights_gen #(.LAMPS(3), .TICK_DIV(1)) u_a (
    .clk(clk), .reset(a_rst), .left(a_l), .right(a_r), .hazard(a_h),
    .l_lamps(a_ll), .r_lamps(a_rl), .busy(a_busy));
  thunderbird_lights_gen #(.LAMPS(3), .TICK_DIV(4)) u_b (
    .clk(clk), .reset(b_rst), .left(b_l), .right(b_r), .hazard(b_h),
    .l_lamps(b_ll), .r_lamps(b_rl), .busy(b_busy));
  thunderbird_lights_gen #(.LAMPS(4), .TICK_DIV(1)) u_c (
    .clk(clk), .reset(c_rst), .left(c_l), .right(c_r), .hazard(c_h),
    .l_lamps(c_ll), .r_lamps(c_rl), .busy(c_busy));
  thunderbird_lights_gen #(.LAMPS(3), .TICK_DIV(2)) u_d (
    .clk(clk), .reset(d_rst), .left(d_l), .right(d_r), .hazard(d_h),
    .l_lamps(d_ll), .r_lamps(d_rl), .busy(d_busy));
  thunderbird_lights_gen #(.LAMPS(5), .TICK_DIV(3)) u_e (
    .clk(clk), .reset(e_rst), .left(e_l), .right(e_r), .hazard(e_h),
    .l_lamps(e_ll), .r_lamps(e_rl), .busy(e_busy));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [2:0] exp_a [5];
    exp_a[0] = 3'b001; exp_a[1] = 3'b011; exp_a[2] = 3'b111;
    exp_a[3] = 3'b000; exp_a[4] = 3'b001;

    {a_rst, b_rst, c_rst, d_rst, e_rst} = 5'b11111;
    {a_l, a_r, a_h} = 3'b000; {b_l, b_r, b_h} = 3'b000;
    {c_l, c_r, c_h} = 3'b000; {d_l, d_r, d_h} = 3'b000;
    {e_l, e_r, e_h} = 3'b000;

    // ---- 1: LAMPS=3 TICK_DIV=1, left held
    edges(2);
    chk("a_rst_l", 8'(a_ll), 8'h00);
    chk("a_rst_r", 8'(a_rl), 8'h00);
    chk("a_rst_busy", 8'(a_busy), 8'h00);
    a_rst = 1'b0; a_l = 1'b1;
    for (int i = 0; i < 5; i++) begin
      edges(1);
      chk($sformatf("t1_l%0d", i), 8'(a_ll), 8'(exp_a[i]));
      chk($sformatf("t1_r%0d", i), 8'(a_rl), 8'h00);
      chk($sformatf("t1_busy%0d", i), 8'(a_busy), (i == 3) ? 8'h00 : 8'h01);
    end
    a_l = 1'b0;
    edges(1); chk("t1_drop_l", 8'(a_ll), 8'h03);
    edges(1); chk("t1_drop_l2", 8'(a_ll), 8'h07);
    edges(1); chk("t1_end", 8'(a_ll), 8'h00);

    // ---- 2: LAMPS=3 TICK_DIV=4, one-cycle right on a tick
    b_rst = 1'b0;
    edges(3);
    b_r = 1'b1;
    edges(1);
    b_r = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("t2_r%0d", i), 8'(b_rl), (i < 4) ? 8'h01 : (i < 8) ? 8'h03 : 8'h07);
      chk($sformatf("t2_l%0d", i), 8'(b_ll), 8'h00);
      edges(1);
    end
    chk("t2_end_r", 8'(b_rl), 8'h00);
    chk("t2_end_busy", 8'(b_busy), 8'h00);
    edges(4);
    chk("t2_stay_idle", 8'(b_rl), 8'h00);

    // ---- 3: LAMPS=4 TICK_DIV=1, left+right acts as hazard
    c_rst = 1'b0; c_l = 1'b1; c_r = 1'b1;
    for (int i = 0; i < 4; i++) begin
      edges(1);
      chk($sformatf("t3_lr_l%0d", i), 8'(c_ll), (i % 2 == 0) ? 8'h0f : 8'h00);
      chk($sformatf("t3_lr_r%0d", i), 8'(c_rl), (i % 2 == 0) ? 8'h0f : 8'h00);
      chk($sformatf("t3_lr_b%0d", i), 8'(c_busy), (i % 2 == 0) ? 8'h01 : 8'h00);
    end
    c_l = 1'b0; c_r = 1'b0;
    edges(1); chk("t3_release", 8'(c_ll), 8'h00);
    c_h = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edges(1);
      chk($sformatf("t3_hz_l%0d", i), 8'(c_ll), (i % 2 == 0) ? 8'h0f : 8'h00);
      chk($sformatf("t3_hz_r%0d", i), 8'(c_rl), (i % 2 == 0) ? 8'h0f : 8'h00);
    end
    c_h = 1'b0;
    edges(1); chk("t3_hz_off", 8'(c_rl), 8'h00);

    // ---- 4: LAMPS=3 TICK_DIV=1, hazard preempts left sequence
    a_rst = 1'b1; edges(1); a_rst = 1'b0; a_l = 1'b1;
    edges(2); chk("t4_pre", 8'(a_ll), 8'h03);
    a_h = 1'b1;
    edges(1);
    chk("t4_haz_l", 8'(a_ll), 8'h07);
    chk("t4_haz_r", 8'(a_rl), 8'h07);
    chk("t4_haz_busy", 8'(a_busy), 8'h01);
    a_h = 1'b0; a_l = 1'b0;
    edges(1);
    chk("t4_off_l", 8'(a_ll), 8'h00);
    chk("t4_off_busy", 8'(a_busy), 8'h00);
    edges(1); chk("t4_idle", 8'(a_ll), 8'h00);

    // ---- 5: LAMPS=3 TICK_DIV=2, reset mid-sequence on a tick edge
    d_rst = 1'b0;
    edges(1);
    d_r = 1'b1;
    edges(1); chk("t5_s1", 8'(d_rl), 8'h01);
    edges(1); chk("t5_s1_hold", 8'(d_rl), 8'h01);
    edges(1); chk("t5_s2", 8'(d_rl), 8'h03);
    edges(1);
    d_rst = 1'b1;
    edges(1);
    chk("t5_rst_r", 8'(d_rl), 8'h00);
    chk("t5_rst_busy", 8'(d_busy), 8'h00);
    d_rst = 1'b0;
    edges(1); chk("t5_wait", 8'(d_rl), 8'h00);
    edges(1); chk("t5_restart", 8'(d_rl), 8'h01);
    d_r = 1'b0;
    edges(6); chk("t5_done", 8'(d_rl), 8'h00);

    // ---- 6: LAMPS=5 TICK_DIV=3, off-tick pulse and opposite request ignored
    e_rst = 1'b0;
    e_l = 1'b1;
    edges(1);
    e_l = 1'b0;
    edges(2);
    chk("t6_pulse_l", 8'(e_ll), 8'h00);
    chk("t6_pulse_busy", 8'(e_busy), 8'h00);
    e_l = 1'b1;
    edges(3);
    e_l = 1'b0;
    chk("t6_s1", 8'(e_ll), 8'h01);
    edges(2);
    e_r = 1'b1;
    edges(1);
    e_r = 1'b0;
    chk("t6_s2_l", 8'(e_ll), 8'h03);
    chk("t6_s2_r", 8'(e_rl), 8'h00);
    edges(3); chk("t6_s3", 8'(e_ll), 8'h07);
    chk("t6_s3_r", 8'(e_rl), 8'h00);
    edges(3); chk("t6_s4", 8'(e_ll), 8'h0f);
    edges(3); chk("t6_s5", 8'(e_ll), 8'h1f);
    edges(3);
    chk("t6_end_l", 8'(e_ll), 8'h00);
    chk("t6_end_busy", 8'(e_busy), 8'h00);
    edges(3);
    chk("t6_idle_r", 8'(e_rl), 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
